// File: rtl/fht_pkg.sv
// Shared constants and types for the FHT front end: word width, frame length and idle fill value.
package fht_pkg;
  localparam int FHT_WIDTH = 8;
  localparam int FHT_FRAME = 4;
  localparam int FHT_DEPTH = 4;

  typedef logic [$clog2(FHT_FRAME)-1:0] slot_t;

  localparam logic [FHT_WIDTH-1:0] FHT_IDLE_WORD = '0;
endpackage

// File: rtl/fht_word_fifo.sv
// Synchronous word FIFO with a combinational head. A push while full is accepted only if a pop
// frees the slot on the same edge; a pop while empty does nothing.
module fht_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d, fill;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en, rd_en;

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_comb begin
    fill    = wr_q - rd_q;
    full_o  = (fill == PW'(DEPTH));
    empty_o = (fill == '0);
    rd_en   = pop_i && !empty_o;
    wr_en   = push_i && (!full_o || rd_en);
    wr_d    = wr_q + PW'(wr_en);
    rd_d    = rd_q + PW'(rd_en);
    mem_d   = mem_q;
    if (wr_en) mem_d[wr_q[AW-1:0]] = data_i;
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign level_o = LW'(fill);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/fht_chip_framer.sv
// Packs serial chips LSB-first into words, queues them, and issues one word per FHT frame on the
// edge into the last slot, holding it stable for the whole frame.
module fht_chip_framer
  import fht_pkg::*;
#(
  parameter int               WIDTH     = FHT_WIDTH,
  parameter int               DEPTH     = FHT_DEPTH,
  parameter int               FRAME     = FHT_FRAME,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(FHT_IDLE_WORD)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       chip_i,
  input  logic                       chip_valid_i,
  input  logic                       sync_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       word_valid_o,
  output logic [$clog2(FRAME)-1:0]   slot_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);
  localparam int SW = $clog2(FRAME);
  localparam int BW = $clog2(WIDTH);

  logic [SW-1:0]    slot_q, slot_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d, bit_idx;
  logic [WIDTH-1:0] pack_q, pack_d, data_q, data_d, fifo_head;
  logic             word_valid_q, word_valid_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             ever_pushed_q, ever_pushed_d;
  logic             push, pop, issue, fifo_full, fifo_empty, push_ok;

  always_comb begin
    slot_d   = (slot_q == SW'(FRAME - 1)) ? '0 : slot_q + 1'b1;
    issue    = (slot_q == SW'(FRAME - 2));
    pop      = issue && !fifo_empty;
    bit_idx  = sync_i ? '0 : bitcnt_q;
    pack_d   = pack_q;
    bitcnt_d = bitcnt_q;
    push     = 1'b0;
    if (chip_valid_i) begin
      pack_d[bit_idx] = chip_i;
      push            = (bit_idx == BW'(WIDTH - 1));
      bitcnt_d        = push ? '0 : bit_idx + 1'b1;
    end
    push_ok       = push && (!fifo_full || pop);
    overflow_d    = overflow_q | (push && !push_ok);
    ever_pushed_d = ever_pushed_q | push_ok;
    data_d        = data_q;
    word_valid_d  = word_valid_q;
    underflow_d   = underflow_q;
    // Idle frames before the first word ever arrives are start-up, not starvation.
    if (issue) begin
      data_d       = pop ? fifo_head : IDLE_WORD;
      word_valid_d = pop;
      if (!pop && ever_pushed_q) underflow_d = 1'b1;
    end
  end

  fht_word_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pack_d),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level_o)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q        <= '0;
      bitcnt_q      <= '0;
      pack_q        <= '0;
      data_q        <= IDLE_WORD;
      word_valid_q  <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      ever_pushed_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      bitcnt_q      <= bitcnt_d;
      pack_q        <= pack_d;
      data_q        <= data_d;
      word_valid_q  <= word_valid_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      ever_pushed_q <= ever_pushed_d;
    end
  end

  assign data_o       = data_q;
  assign word_valid_o = word_valid_q;
  assign slot_o       = slot_q;
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;
endmodule

// File: tb/tb_fht_chip_framer.sv
// Bench for fht_chip_framer: a default-frame instance and a long-frame instance share one chip
// stream and are each compared every cycle against a queue-based frame model.
module tb_fht_chip_framer;
  import fht_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int F0 = 4;
  localparam int F1 = 32;
  localparam logic [W-1:0] IDLE = '0;

  logic       clk, rst, chip_i, chip_valid_i, sync_i;
  logic [7:0] data0, data1;
  logic       wv0, wv1, ovf0, ovf1, unf0, unf1;
  logic [1:0] slot0;
  logic [4:0] slot1;
  logic [2:0] lvl0, lvl1;

  fht_chip_framer dut (
    .clk(clk), .reset(rst), .chip_i(chip_i), .chip_valid_i(chip_valid_i), .sync_i(sync_i),
    .data_o(data0), .word_valid_o(wv0), .slot_o(slot0), .fifo_level_o(lvl0),
    .overflow_o(ovf0), .underflow_o(unf0)
  );

  fht_chip_framer #(.FRAME(F1)) dut_slow (
    .clk(clk), .reset(rst), .chip_i(chip_i), .chip_valid_i(chip_valid_i), .sync_i(sync_i),
    .data_o(data1), .word_valid_o(wv1), .slot_o(slot1), .fifo_level_o(lvl1),
    .overflow_o(ovf1), .underflow_o(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state: one shared packer, one frame/queue per instance.
  int         m_bits;
  logic [7:0] m_word;
  int         m_slot [2];
  logic [7:0] m_data [2];
  bit         m_wv [2], m_ovf [2], m_unf [2], m_ever [2];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_slow_q[$];
  logic [W-1:0] got_fast_q[$];
  logic [W-1:0] got_slow_q[$];

  typedef struct packed {
    logic       cv, ch, sy;
    logic [7:0] e_data;
    logic       e_wv;
    slot_t      e_slot;
    logic [2:0] e_lvl;
    logic       e_ovf, e_unf;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_bits = 0;
    m_word = '0;
    for (int k = 0; k < 2; k++) begin
      m_slot[k] = 0; m_data[k] = IDLE; m_wv[k] = 0;
      m_ovf[k] = 0; m_unf[k] = 0; m_ever[k] = 0;
    end
    exp_q.delete();
    exp_slow_q.delete();
  endtask

  task automatic model_inst(input int k, input bit complete, input logic [7:0] cw);
    int frame, pre;
    bit issue, do_pop;
    logic [7:0] head;
    frame  = (k == 0) ? F0 : F1;
    pre    = (k == 0) ? exp_q.size() : exp_slow_q.size();
    issue  = (m_slot[k] == frame - 2);
    do_pop = issue && (pre > 0);
    if (do_pop) begin
      if (k == 0) head = exp_q.pop_front();
      else        head = exp_slow_q.pop_front();
      m_data[k] = head;
      m_wv[k]   = 1;
    end else if (issue) begin
      m_data[k] = IDLE;
      m_wv[k]   = 0;
      if (m_ever[k]) m_unf[k] = 1;
    end
    if (complete) begin
      if (pre < D || do_pop) begin
        if (k == 0) exp_q.push_back(cw);
        else        exp_slow_q.push_back(cw);
        m_ever[k] = 1;
      end else begin
        m_ovf[k] = 1;
      end
    end
    m_slot[k] = (m_slot[k] + 1) % frame;
  endtask

  task automatic model_step(input bit cv, input bit ch, input bit sy);
    bit complete;
    complete = 0;
    if (cv) begin
      if (sy) m_bits = 0;
      m_word[m_bits] = ch;
      m_bits++;
      if (m_bits == W) begin
        complete = 1;
        m_bits = 0;
      end
    end
    model_inst(0, complete, m_word);
    model_inst(1, complete, m_word);
  endtask

  task automatic check_all();
    chk("fast_cycle", {data0, wv0, 8'(slot0), 4'(lvl0), ovf0, unf0},
        {m_data[0], m_wv[0], 8'(m_slot[0]), 4'(exp_q.size()), m_ovf[0], m_unf[0]});
    chk("slow_cycle", {data1, wv1, 8'(slot1), 4'(lvl1), ovf1, unf1},
        {m_data[1], m_wv[1], 8'(m_slot[1]), 4'(exp_slow_q.size()), m_ovf[1], m_unf[1]});
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then compare on the next fall.
  task automatic tick(input bit cv, input bit ch, input bit sy);
    chip_valid_i = cv;
    chip_i       = ch;
    sync_i       = sy;
    @(posedge clk);
    model_step(cv, ch, sy);
    @(negedge clk);
    check_all();
    if (slot0 == 2'(F0 - 1) && wv0) got_fast_q.push_back(data0);
    if (slot1 == 5'(F1 - 1) && wv1) got_slow_q.push_back(data1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  task automatic send_word(input logic [7:0] w, input bit with_sync);
    for (int i = 0; i < W; i++) tick(1, w[i], with_sync && (i == 0));
  endtask

  // Asserted mid-cycle so the async path is what clears the outputs.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    chip_valid_i = 0; chip_i = 0; sync_i = 0;
    #1;
    chk("reset_fast", {data0, wv0, 8'(slot0), 4'(lvl0), ovf0, unf0}, {IDLE, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0});
    chk("reset_slow", {data1, wv1, 8'(slot1), 4'(lvl1), ovf1, unf1}, {IDLE, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_fast_q.delete();
    got_slow_q.delete();
  endtask

  initial begin
    logic [7:0] w [6];
    rst = 1'b1; chip_i = 0; chip_valid_i = 0; sync_i = 0;
    model_reset();

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd3, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd3, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 3'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd1, 3'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd2, 3'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h4D, 1'b1, 2'd3, 3'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h4D, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h4D, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h4D, 1'b1, 2'd2, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd3, 3'd0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1};

    @(negedge clk);
    do_reset();

    // Word 8'h4D, issued once, then a starved frame.
    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].cv, vecs[i].ch, vecs[i].sy);
      chk($sformatf("vec%0d", i), {data0, wv0, 8'(slot0), 4'(lvl0), ovf0, unf0},
          {vecs[i].e_data, vecs[i].e_wv, 8'(vecs[i].e_slot), 4'(vecs[i].e_lvl), vecs[i].e_ovf, vecs[i].e_unf});
    end

    // Resync after a 5-chip partial word.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, (i % 2 == 0), (i == 0));
    send_word(8'hFF, 1);
    idle(2);
    chk("sync_issue", {data0, wv0, ovf0, unf0}, {8'hFF, 1'b1, 1'b0, 1'b0});
    chk("sync_count", got_fast_q.size(), 1);
    if (got_fast_q.size() > 0) chk("sync_word", got_fast_q[0], 8'hFF);

    // Six back-to-back words into the long-frame instance.
    do_reset();
    for (int i = 0; i < 6; i++) w[i] = {4'(i + 1), 4'($urandom_range(0, 15))};
    for (int i = 0; i < 6; i++) send_word(w[i], 0);
    chk("ovf_level", lvl1, 3'd4);
    chk("ovf_flag", ovf1, 1'b1);
    idle(150);
    chk("ovf_issued_count", got_slow_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_slow_q.size()) chk($sformatf("ovf_issued%0d", i), got_slow_q[i], w[i]);
    chk("ovf_then_underflow", unf1, 1'b1);

    // Push lands on the pop edge while full.
    do_reset();
    for (int i = 0; i < 5; i++) send_word(8'h30 + 8'(i), 0);
    chk("full_level", lvl1, 3'd4);
    idle(15);
    send_word(8'hA5, 0);
    chk("pushpop_full", {lvl1, ovf1, wv1}, {3'd4, 1'b0, 1'b1});

    // Reset with 3 words queued and a partial word in the packer.
    do_reset();
    for (int i = 0; i < 3; i++) send_word(8'h60 + 8'(i), 0);
    tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0);
    chk("pre_reset_level", lvl1, 3'd3);
    do_reset();
    idle(3);
    chk("post_reset_issue", {data0, wv0, 8'(slot0), unf0}, {IDLE, 1'b0, 8'd3, 1'b0});

    // Random chip stream with an asynchronous reset in the middle.
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      else tick($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
